// File: rtl/cube_point_scanner_pkg.sv
// rtl/cube_point_scanner_pkg.sv - shared point type and scan-state encoding
package cube_point_scanner_pkg;

  localparam int DEF_ROW_W = 4;
  localparam int DEF_COL_W = 4;

  typedef logic [DEF_ROW_W+DEF_COL_W-1:0] point_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHOW,
    ST_BLANK
  } scan_state_t;

endpackage

// File: rtl/cube_point_scanner_ram.sv
// rtl/cube_point_scanner_ram.sv - dual-bank point store, bank select is the address MSB
module point_bank_ram
  import cube_point_scanner_pkg::*;
#(
  parameter int PW = 8,
  parameter int AW = 8
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW:0]   wr_addr,
  input  logic [PW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW:0]   rd_addr,
  output logic [PW-1:0] rd_data
);

  logic [PW-1:0] mem [2**(AW+1)];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cube_point_scanner.sv
// rtl/cube_point_scanner.sv - double-buffered point list scanned onto one-hot row/col lines
module cube_point_scanner
  import cube_point_scanner_pkg::*;
#(
  parameter int ROW_W      = 4,
  parameter int COL_W      = 4,
  parameter int MAX_POINTS = 256,
  parameter int DWELL      = 4,
  parameter int BLANK      = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ROW_W+COL_W-1:0]   wr_point,
  input  logic                     wr_last,
  output logic [(1<<ROW_W)-1:0]    row,
  output logic [(1<<COL_W)-1:0]    col,
  output logic                     scan_done,
  output logic                     frame_swapped
);

  localparam int PW    = ROW_W + COL_W;
  localparam int AW    = $clog2(MAX_POINTS);
  localparam int CW    = AW + 1;
  localparam int N_ROW = 1 << ROW_W;
  localparam int N_COL = 1 << COL_W;

  logic          wr_bank;
  logic          pending;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] count0, count1;
  logic [CW-1:0] disp_count, new_count, disp_count_next;

  scan_state_t   state, state_n;
  logic [15:0]   phase, phase_n;
  logic [AW-1:0] idx, idx_n;
  logic [PW-1:0] rd_data;

  logic accept, close, point_end, pass_end, swap;
  logic last_show, last_blank;

  assign wr_ready = ~pending;
  assign accept   = wr_valid & ~pending;
  assign close    = accept & (wr_last | (wr_addr == AW'(MAX_POINTS - 1)));

  // Display bank is always the complement of the write bank.
  assign disp_count      = wr_bank ? count0 : count1;
  assign new_count       = wr_bank ? count1 : count0;
  assign disp_count_next = swap ? new_count : disp_count;

  assign last_show  = (state == ST_SHOW)  && (phase == 16'(DWELL - 1));
  assign last_blank = (state == ST_BLANK) && (phase == 16'(BLANK - 1));
  assign point_end  = enable & ((BLANK == 0) ? last_show : last_blank);
  assign pass_end   = point_end & ({1'b0, idx} == disp_count - CW'(1));
  assign swap       = pending & (pass_end | (state == ST_IDLE));

  assign scan_done     = pass_end;
  assign frame_swapped = swap;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_bank <= 1'b0;
      pending <= 1'b0;
      wr_addr <= '0;
      count0  <= '0;
      count1  <= '0;
    end else begin
      if (swap) begin
        wr_bank <= ~wr_bank;
        pending <= 1'b0;
      end
      if (accept) begin
        if (close) begin
          wr_addr <= '0;
          pending <= 1'b1;
          if (wr_bank) count1 <= {1'b0, wr_addr} + CW'(1);
          else         count0 <= {1'b0, wr_addr} + CW'(1);
        end else begin
          wr_addr <= wr_addr + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      phase <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    idx_n   = idx;
    if (!enable) begin
      state_n = ST_IDLE;
      phase_n = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          idx_n   = '0;
          phase_n = '0;
          if (disp_count_next != '0) state_n = ST_FETCH;
        end
        ST_FETCH: begin
          state_n = ST_SHOW;
          phase_n = '0;
        end
        ST_SHOW: begin
          if (phase == 16'(DWELL - 1)) begin
            state_n = ST_BLANK;
            phase_n = '0;
          end else begin
            phase_n = phase + 16'd1;
          end
        end
        ST_BLANK: phase_n = phase + 16'd1;
        default:  state_n = ST_IDLE;
      endcase
      // End of a point's period overrides the per-state stepping above.
      if (point_end) begin
        phase_n = '0;
        if (pass_end) begin
          idx_n   = '0;
          state_n = (disp_count_next != '0) ? ST_FETCH : ST_IDLE;
        end else begin
          idx_n   = idx + AW'(1);
          state_n = ST_FETCH;
        end
      end
    end
  end

  point_bank_ram #(
    .PW (PW),
    .AW (AW)
  ) u_ram (
    .clock   (clock),
    .wr_en   (accept),
    .wr_addr ({wr_bank, wr_addr}),
    .wr_data (wr_point),
    .rd_en   (state == ST_FETCH),
    .rd_addr ({~wr_bank, idx}),
    .rd_data (rd_data)
  );

  assign row = (state == ST_SHOW) ? (N_ROW'(1) << rd_data[PW-1:COL_W]) : '0;
  assign col = (state == ST_SHOW) ? (N_COL'(1) << rd_data[COL_W-1:0]) : '0;

endmodule
